// File: rtl/key_to_note_pkg.sv
// Shared scan codes, note frequency table and half-period helper for key_to_note.
package key_to_note_pkg;

  localparam int unsigned HP_W      = 21;
  localparam int unsigned NUM_NOTES = 12;

  localparam logic [7:0] KEY_Q           = 8'h15;
  localparam logic [7:0] KEY_W           = 8'h1D;
  localparam logic [7:0] KEY_E           = 8'h24;
  localparam logic [7:0] KEY_R           = 8'h2D;
  localparam logic [7:0] KEY_T           = 8'h2C;
  localparam logic [7:0] KEY_Y           = 8'h35;
  localparam logic [7:0] KEY_U           = 8'h3C;
  localparam logic [7:0] KEY_I           = 8'h43;
  localparam logic [7:0] KEY_O           = 8'h44;
  localparam logic [7:0] KEY_P           = 8'h4D;
  localparam logic [7:0] KEY_OPEN_BRACE  = 8'h54;
  localparam logic [7:0] KEY_CLOSE_BRACE = 8'h5B;
  localparam logic [7:0] KEY_Z           = 8'h1A;
  localparam logic [7:0] KEY_X           = 8'h22;
  localparam logic [7:0] BREAK_CODE      = 8'hF0;
  localparam logic [7:0] EXT_CODE        = 8'hE0;

  // Chromatic C4..B4, index-aligned with NOTE_MHZ.
  localparam logic [7:0] NOTE_CODE [NUM_NOTES] = '{
    KEY_Q, KEY_W, KEY_E, KEY_R, KEY_T, KEY_Y,
    KEY_U, KEY_I, KEY_O, KEY_P, KEY_OPEN_BRACE, KEY_CLOSE_BRACE
  };

  localparam int unsigned NOTE_MHZ [NUM_NOTES] = '{
    261626, 277183, 293665, 311127, 329628, 349228,
    369994, 391995, 415305, 440000, 466164, 493883
  };

  typedef struct packed {
    logic            hit;
    logic [HP_W-1:0] half_period;
  } lut_out_t;

  // Elaboration-time only: floor(clk_hz*1000 / (2*f_mhz)).
  function automatic logic [HP_W-1:0] calc_half_period(input longint unsigned clk_hz,
                                                       input longint unsigned f_mhz);
    longint unsigned q;
    q = (clk_hz * 64'd1000) / (64'd2 * f_mhz);
    return HP_W'(q);
  endfunction

endpackage

// File: rtl/note_period_lut.sv
// Combinational scan code -> {hit, half_period} lookup; constants fixed at elaboration.
module note_period_lut
  import key_to_note_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000
) (
  input  logic [7:0] code,
  output lut_out_t   lut_out
);

  logic [HP_W-1:0] hp_tab [NUM_NOTES];

  for (genvar g = 0; g < NUM_NOTES; g++) begin : g_note
    localparam logic [HP_W-1:0] HP = calc_half_period(64'(CLK_FREQ_HZ), 64'(NOTE_MHZ[g]));
    assign hp_tab[g] = HP;
  end

  always_comb begin
    lut_out = '0;
    for (int i = 0; i < NUM_NOTES; i++) begin
      if (code == NOTE_CODE[i]) begin
        lut_out.hit         = 1'b1;
        lut_out.half_period = hp_tab[i];
      end
    end
  end

endmodule

// File: rtl/key_to_note.sv
// PS/2 Set-2 make/break decoder driving a tone half-period (C4..B4 on Q..]).
// Optional octave shift on Z/X keys under KEY_TO_NOTE_OCTAVE_SHIFT_EN.
module key_to_note
  import key_to_note_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        data_valid,
  input  logic [7:0]  data,
  output logic [20:0] half_period,
  output logic        note_on
);

  lut_out_t        lut;
  logic [HP_W-1:0] emit_hp;

  logic [HP_W-1:0] half_period_q, half_period_d;
  logic            note_on_q, note_on_d;
  logic            break_pending_q, break_pending_d;
  logic            extended_pending_q, extended_pending_d;
  logic [7:0]      held_code_q, held_code_d;

  note_period_lut #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_lut (
    .code    (data),
    .lut_out (lut)
  );

`ifdef KEY_TO_NOTE_OCTAVE_SHIFT_EN
  logic signed [2:0] octave_q, octave_d;

  // Negative octave lengthens the period (lower pitch), positive shortens it.
  always_comb begin
    if (octave_q[2]) emit_hp = lut.half_period << 2'(-octave_q);
    else             emit_hp = lut.half_period >> 2'(octave_q);
  end
`else
  assign emit_hp = lut.half_period;
`endif

  always_comb begin
    half_period_d      = half_period_q;
    note_on_d          = note_on_q;
    break_pending_d    = break_pending_q;
    extended_pending_d = extended_pending_q;
    held_code_d        = held_code_q;
`ifdef KEY_TO_NOTE_OCTAVE_SHIFT_EN
    octave_d           = octave_q;
`endif
    if (data_valid) begin
      if (data == BREAK_CODE) begin
        break_pending_d = 1'b1;
      end else if (data == EXT_CODE) begin
        extended_pending_d = 1'b1;
      end else if (extended_pending_q) begin
        // Extended keys are swallowed so they never alias a top-row note.
        extended_pending_d = 1'b0;
        break_pending_d    = 1'b0;
      end else begin
        break_pending_d = 1'b0;
        if (lut.hit) begin
          if (!break_pending_q) begin
            half_period_d = emit_hp;
            note_on_d     = 1'b1;
            held_code_d   = data;
          end else if (data == held_code_q) begin
            half_period_d = '0;
            note_on_d     = 1'b0;
          end
        end
`ifdef KEY_TO_NOTE_OCTAVE_SHIFT_EN
        else if (!break_pending_q && data == KEY_Z) begin
          if (octave_q > -3'sd2) octave_d = octave_q - 3'sd1;
        end else if (!break_pending_q && data == KEY_X) begin
          if (octave_q < 3'sd2) octave_d = octave_q + 3'sd1;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      half_period_q      <= '0;
      note_on_q          <= 1'b0;
      break_pending_q    <= 1'b0;
      extended_pending_q <= 1'b0;
      held_code_q        <= '0;
`ifdef KEY_TO_NOTE_OCTAVE_SHIFT_EN
      octave_q           <= '0;
`endif
    end else begin
      half_period_q      <= half_period_d;
      note_on_q          <= note_on_d;
      break_pending_q    <= break_pending_d;
      extended_pending_q <= extended_pending_d;
      held_code_q        <= held_code_d;
`ifdef KEY_TO_NOTE_OCTAVE_SHIFT_EN
      octave_q           <= octave_d;
`endif
    end
  end

  assign half_period = half_period_q;
  assign note_on     = note_on_q;

endmodule

// File: tb/tb_key_to_note.sv
// Directed self-checking bench for key_to_note at CLK_FREQ_HZ = 100 MHz.
module tb_key_to_note;

  logic        clk;
  logic        rst_n;
  logic        data_valid;
  logic [7:0]  data;
  logic [20:0] half_period;
  logic        note_on;

  int checks;
  int failures;

  key_to_note #(.CLK_FREQ_HZ(100_000_000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_valid  (data_valid),
    .data        (data),
    .half_period (half_period),
    .note_on     (note_on)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one byte for one clock; outputs are sampled on the following negedge.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    data       = b;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [20:0] hp, input logic on);
    check_eq({tag, "_hp"}, 32'(half_period), 32'(hp));
    check_eq({tag, "_on"}, 32'(note_on), 32'(on));
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    data_valid = 1'b0;
    data       = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    expect_out("reset", 21'd0, 1'b0);

    send_byte(8'h15); expect_out("make_q", 21'd191112, 1'b1);
    send_byte(8'h2C); expect_out("make_t", 21'd151686, 1'b1);
    send_byte(8'h3C); expect_out("make_u", 21'd135137, 1'b1);
    send_byte(8'h24); expect_out("make_e", 21'd170262, 1'b1);
    send_byte(8'h24); expect_out("repeat_e", 21'd170262, 1'b1);

    send_byte(8'hF0); expect_out("f0_only", 21'd170262, 1'b1);
    send_byte(8'h15); expect_out("break_other", 21'd170262, 1'b1);
    send_byte(8'hF0);
    send_byte(8'h24); expect_out("break_e", 21'd0, 1'b0);

    send_byte(8'h24); expect_out("remake_e", 21'd170262, 1'b1);
    send_byte(8'h1C); expect_out("unmapped", 21'd170262, 1'b1);
    send_byte(8'hE0);
    send_byte(8'h75); expect_out("ext_75", 21'd170262, 1'b1);
    send_byte(8'hE0);
    send_byte(8'h15); expect_out("ext_swallow_q", 21'd170262, 1'b1);
    send_byte(8'h15); expect_out("make_q_after_ext", 21'd191112, 1'b1);

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      data       = 8'h4D + 8'(i);
      data_valid = 1'b0;
    end
    @(negedge clk);
    expect_out("no_valid", 21'd191112, 1'b1);

    send_byte(8'hF0);
    send_byte(8'hF0);
    send_byte(8'h15); expect_out("f0_f0_break_q", 21'd0, 1'b0);
    send_byte(8'h15); expect_out("remake_q", 21'd191112, 1'b1);

    send_byte(8'hF0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    expect_out("mid_reset", 21'd0, 1'b0);
    send_byte(8'h4D); expect_out("make_p_after_reset", 21'd113636, 1'b1);

    send_byte(8'h5B); expect_out("make_close_brace", 21'd101238, 1'b1);
    send_byte(8'h54); expect_out("make_open_brace", 21'd107258, 1'b1);

`ifdef KEY_TO_NOTE_OCTAVE_SHIFT_EN
    send_byte(8'h22); expect_out("x_keeps_note", 21'd107258, 1'b1);
    send_byte(8'h4D); expect_out("p_oct_up", 21'd56818, 1'b1);
    send_byte(8'hF0);
    send_byte(8'h1A); expect_out("z_break_ignored", 21'd56818, 1'b1);
    repeat (4) send_byte(8'h1A);
    send_byte(8'h4D); expect_out("p_oct_sat_low", 21'd454544, 1'b1);
`else
    send_byte(8'h1A); expect_out("z_unmapped", 21'd107258, 1'b1);
    send_byte(8'h22); expect_out("x_unmapped", 21'd107258, 1'b1);
    send_byte(8'h4D); expect_out("p_no_octave", 21'd113636, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
